// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: round-robin sharing of one combinational instruction ROM
// between the instruction fetch port (m0) and the debug/loader port (m1).
// One transaction is outstanding at a time. The response word is registered
// and held under a valid/ready handshake. When the owner's response is
// consumed, a new grant can be taken in the same cycle (back-to-back).
// Optional macro ROM_ARB_STATS_EN adds grant/stall/error statistics counters.
module rom_fetch_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DATA_W-1:0] m0_rsp_data,
    output logic              m0_rsp_err,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DATA_W-1:0] m1_rsp_data,
    output logic              m1_rsp_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
    output logic [31:0]       stat_stall,
    output logic [15:0]       stat_err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              m0_rsp_valid_q, m0_rsp_valid_d;
    logic              m1_rsp_valid_q, m1_rsp_valid_d;
    logic [DATA_W-1:0] m0_rsp_data_q, m0_rsp_data_d;
    logic [DATA_W-1:0] m1_rsp_data_q, m1_rsp_data_d;
    logic              m0_rsp_err_q, m0_rsp_err_d;
    logic              m1_rsp_err_q, m1_rsp_err_d;

    logic              owner_ready;
    logic              owner_done;
    logic              accept_slot;
    logic              grant_valid;
    logic              grant_port;
    logic [ADDR_W-1:0] gnt_addr;
    logic              addr_err;
    logic [IDX_W-1:0]  rom_idx;
    logic [DATA_W-1:0] rsp_word;

`ifdef ROM_ARB_STATS_EN
    logic [31:0] stat_grant0_q, stat_grant0_d;
    logic [31:0] stat_grant1_q, stat_grant1_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [15:0] stat_err_q, stat_err_d;

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
    assign stat_stall  = stat_stall_q;
    assign stat_err    = stat_err_q;
`endif

    assign m0_rsp_valid = m0_rsp_valid_q;
    assign m1_rsp_valid = m1_rsp_valid_q;
    assign m0_rsp_data  = m0_rsp_data_q;
    assign m1_rsp_data  = m1_rsp_data_q;
    assign m0_rsp_err   = m0_rsp_err_q;
    assign m1_rsp_err   = m1_rsp_err_q;

    // Arbitration, address check and ROM drive for the current cycle
    always_comb begin
        owner_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;
        owner_done  = owner_q ? (m1_rsp_valid_q && m1_rsp_ready)
                              : (m0_rsp_valid_q && m0_rsp_ready);
        accept_slot = (state_q == IDLE) || ((state_q == RSP) && owner_done);

        grant_valid = accept_slot && (m0_req_valid || m1_req_valid);
        if (m0_req_valid && m1_req_valid) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = m1_req_valid;
        end

        gnt_addr = grant_port ? m1_addr : m0_addr;
        addr_err = (gnt_addr[1:0] != 2'b00) || (gnt_addr[ADDR_W-1:IDX_W+2] != '0);
        rom_idx  = gnt_addr[IDX_W+1:2];

        m0_req_ready = grant_valid && !grant_port;
        m1_req_ready = grant_valid && grant_port;
        rom_ce       = grant_valid && !addr_err;
        rom_addr     = rom_ce ? ADDR_W'(rom_idx) : '0;
        rsp_word     = addr_err ? '0 : rom_inst;
    end

    // Next-state: a new grant takes ownership; otherwise a consumed response retires
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        m0_rsp_valid_d = m0_rsp_valid_q;
        m1_rsp_valid_d = m1_rsp_valid_q;
        m0_rsp_data_d  = m0_rsp_data_q;
        m1_rsp_data_d  = m1_rsp_data_q;
        m0_rsp_err_d   = m0_rsp_err_q;
        m1_rsp_err_d   = m1_rsp_err_q;
`ifdef ROM_ARB_STATS_EN
        stat_grant0_d  = stat_grant0_q;
        stat_grant1_d  = stat_grant1_q;
        stat_stall_d   = stat_stall_q;
        stat_err_d     = stat_err_q;
        if ((state_q == RSP) && !owner_ready) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
`endif

        if (grant_valid) begin
            state_d      = RSP;
            owner_d      = grant_port;
            last_grant_d = grant_port;
            if (grant_port) begin
                m0_rsp_valid_d = 1'b0;
                m1_rsp_valid_d = 1'b1;
                m1_rsp_data_d  = rsp_word;
                m1_rsp_err_d   = addr_err;
            end else begin
                m0_rsp_valid_d = 1'b1;
                m1_rsp_valid_d = 1'b0;
                m0_rsp_data_d  = rsp_word;
                m0_rsp_err_d   = addr_err;
            end
`ifdef ROM_ARB_STATS_EN
            if (grant_port) begin
                stat_grant1_d = stat_grant1_q + 32'd1;
            end else begin
                stat_grant0_d = stat_grant0_q + 32'd1;
            end
            if (addr_err) begin
                stat_err_d = stat_err_q + 16'd1;
            end
`endif
        end else if ((state_q == RSP) && owner_done) begin
            state_d = IDLE;
            if (owner_q) begin
                m1_rsp_valid_d = 1'b0;
            end else begin
                m0_rsp_valid_d = 1'b0;
            end
        end
    end

    // State and response registers; reset discards any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            m0_rsp_valid_q <= 1'b0;
            m1_rsp_valid_q <= 1'b0;
            m0_rsp_data_q  <= '0;
            m1_rsp_data_q  <= '0;
            m0_rsp_err_q   <= 1'b0;
            m1_rsp_err_q   <= 1'b0;
`ifdef ROM_ARB_STATS_EN
            stat_grant0_q  <= '0;
            stat_grant1_q  <= '0;
            stat_stall_q   <= '0;
            stat_err_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            m0_rsp_valid_q <= m0_rsp_valid_d;
            m1_rsp_valid_q <= m1_rsp_valid_d;
            m0_rsp_data_q  <= m0_rsp_data_d;
            m1_rsp_data_q  <= m1_rsp_data_d;
            m0_rsp_err_q   <= m0_rsp_err_d;
            m1_rsp_err_q   <= m1_rsp_err_d;
`ifdef ROM_ARB_STATS_EN
            stat_grant0_q  <= stat_grant0_d;
            stat_grant1_q  <= stat_grant1_d;
            stat_stall_q   <= stat_stall_d;
            stat_err_q     <= stat_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Testbench for rom_fetch_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbiter kept in the bench.
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
    logic        m0_req_ready, m1_req_ready;
    logic [63:0] m0_addr = '0, m1_addr = '0;
    logic        m0_rsp_valid, m1_rsp_valid;
    logic        m0_rsp_ready = 1'b1, m1_rsp_ready = 1'b1;
    logic [31:0] m0_rsp_data, m1_rsp_data;
    logic        m0_rsp_err, m1_rsp_err;
    logic        rom_ce;
    logic [63:0] rom_addr;
    logic [31:0] rom_inst;
`ifdef ROM_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1, stat_stall;
    logic [15:0] stat_err;
`endif

    logic [31:0] rom_mem [64];
    // ROM ignores rom_ce for reads so that a missing error gate shows up as nonzero data
    assign rom_inst = rom_mem[rom_addr[5:0]];

    always #5 clk = ~clk;

    rom_fetch_arbiter #(.ADDR_W(64), .DATA_W(32), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m0_rsp_data(m0_rsp_data), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .m1_rsp_data(m1_rsp_data), .m1_rsp_err(m1_rsp_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
`ifdef ROM_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
        .stat_stall(stat_stall), .stat_err(stat_err)
`endif
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Transaction-level model: which port holds a response, and what it holds
    logic        mv [2];
    logic [31:0] md [2];
    logic        me [2];
    bit          busy;
    int          own, last;
    logic [31:0] cnt_g [2];
    logic [31:0] cnt_stall;
    logic [15:0] cnt_err;
    // Model view of the current cycle
    bit          g_any, g_err;
    int          g_port, g_idx;
    logic        e_rdy0, e_rdy1, e_ce;
    logic [63:0] e_addr;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mv[p] = 1'b0; md[p] = '0; me[p] = 1'b0; cnt_g[p] = '0;
        end
        busy = 0; own = 0; last = 1; cnt_stall = '0; cnt_err = '0;
    endtask

    task automatic model_eval();
        logic [63:0] ga;
        bit          acc;
        acc    = !busy || ((own == 0) ? m0_rsp_ready : m1_rsp_ready);
        g_any  = acc && (m0_req_valid || m1_req_valid);
        if (m0_req_valid && m1_req_valid) g_port = 1 - last;
        else                              g_port = m1_req_valid ? 1 : 0;
        ga     = (g_port == 1) ? m1_addr : m0_addr;
        g_err  = (ga % 4 != 0) || (ga >= 64'd256);
        g_idx  = int'((ga / 4) % 64);
        e_rdy0 = g_any && (g_port == 0);
        e_rdy1 = g_any && (g_port == 1);
        e_ce   = g_any && !g_err;
        e_addr = e_ce ? 64'(g_idx) : 64'd0;
    endtask

    // Apply inputs shortly after a rising edge and evaluate the model
    task automatic drive(input logic v0, input logic [63:0] a0, input logic r0,
                         input logic v1, input logic [63:0] a1, input logic r1);
        m0_req_valid = v0; m0_addr = a0; m0_rsp_ready = r0;
        m1_req_valid = v1; m1_addr = a1; m1_rsp_ready = r1;
        #1;
        model_eval();
    endtask

    // Advance the model across the next rising edge
    task automatic step();
        logic own_rdy;
        own_rdy = (own == 0) ? m0_rsp_ready : m1_rsp_ready;
        if (busy && !own_rdy) cnt_stall++;
        if (g_any) begin
            cnt_g[g_port]++;
            if (g_err) cnt_err++;
            mv[g_port]     = 1'b1;
            mv[1 - g_port] = 1'b0;
            md[g_port]     = g_err ? 32'd0 : rom_mem[g_idx];
            me[g_port]     = g_err;
            busy = 1; own = g_port; last = g_port;
        end else if (busy && own_rdy) begin
            mv[own] = 1'b0;
            busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
        else                           a = 64'($urandom_range(0, 63)) * 4;
        return a;
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({m0_rsp_valid, m1_rsp_valid, rom_ce} !== 3'b000)
            $display("FAIL reset_ctl: got %b want 000", {m0_rsp_valid, m1_rsp_valid, rom_ce});
        else pass_cnt++;
        total_cnt++;
        if ({m0_rsp_data, m1_rsp_data, m0_rsp_err, m1_rsp_err} !== 66'd0)
            $display("FAIL reset_data: got %h want 0", {m0_rsp_data, m1_rsp_data, m0_rsp_err, m1_rsp_err});
        else pass_cnt++;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 64'h0, 1, 1, 64'h4, 1);
        total_cnt++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10)
            $display("FAIL first_tie: got %b want 10", {m0_req_ready, m1_req_ready});
        else pass_cnt++;
        step();
        drive(0, 0, 1, 0, 0, 1);
        total_cnt++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_data !== rom_mem[0])
            $display("FAIL first_rsp: got v=%b d=%h want v=1 d=%h", m0_rsp_valid, m0_rsp_data, rom_mem[0]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_single_read();
        drive(1, 64'h8, 1, 0, 0, 1);
        total_cnt++;
        if ({m0_req_ready, rom_ce, rom_addr} !== {1'b1, 1'b1, 64'd2})
            $display("FAIL single_req: got rdy=%b ce=%b addr=%h want 1 1 2", m0_req_ready, rom_ce, rom_addr);
        else pass_cnt++;
        step();
        drive(0, 0, 1, 0, 0, 1);
        total_cnt++;
        if ({m0_rsp_valid, m0_rsp_data, m0_rsp_err} !== {1'b1, 32'h00100093, 1'b0})
            $display("FAIL single_rsp: got v=%b d=%h e=%b want 1 00100093 0", m0_rsp_valid, m0_rsp_data, m0_rsp_err);
        else pass_cnt++;
        step();
    endtask

    task automatic test_contention();
        int prev;
        prev = -1;
        for (int c = 0; c < 8; c++) begin
            drive(1, 64'h0, 1, 1, 64'h4, 1);
            total_cnt++;
            if ({m0_req_ready, m1_req_ready, rom_ce, rom_addr} !== {e_rdy0, e_rdy1, e_ce, e_addr})
                $display("FAIL contend_grant: got %b%b ce=%b a=%h want %b%b ce=%b a=%h",
                         m0_req_ready, m1_req_ready, rom_ce, rom_addr, e_rdy0, e_rdy1, e_ce, e_addr);
            else pass_cnt++;
            total_cnt++;
            if ((m0_req_ready ? 0 : 1) == prev)
                $display("FAIL contend_alternate: got port %0d twice want alternation", prev);
            else pass_cnt++;
            prev = m0_req_ready ? 0 : 1;
            if (c > 0) begin
                total_cnt++;
                if ({m0_rsp_valid, m0_rsp_data, m1_rsp_valid, m1_rsp_data} !== {mv[0], md[0], mv[1], md[1]} ||
                    (m0_rsp_valid && m0_rsp_data !== rom_mem[0]) || (m1_rsp_valid && m1_rsp_data !== rom_mem[1]) ||
                    (m0_rsp_valid == m1_rsp_valid))
                    $display("FAIL contend_rsp: got v=%b%b d0=%h d1=%h want v=%b%b d0=%h d1=%h",
                             m0_rsp_valid, m1_rsp_valid, m0_rsp_data, m1_rsp_data, mv[0], mv[1], md[0], md[1]);
                else pass_cnt++;
            end
            step();
        end
        drive(0, 0, 1, 0, 0, 1);
        step();
    endtask

    task automatic test_backpressure();
        drive(1, 64'h20, 0, 0, 0, 1);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 1, 64'h10, 1);
            total_cnt++;
            if ({m1_req_ready, rom_ce, m0_rsp_valid, m0_rsp_data} !== {1'b0, 1'b0, 1'b1, rom_mem[8]})
                $display("FAIL bp_hold: got r1=%b ce=%b v0=%b d0=%h want 0 0 1 %h",
                         m1_req_ready, rom_ce, m0_rsp_valid, m0_rsp_data, rom_mem[8]);
            else pass_cnt++;
            step();
        end
        drive(0, 0, 1, 1, 64'h10, 1);
        total_cnt++;
        if ({m1_req_ready, rom_ce, rom_addr} !== {1'b1, 1'b1, 64'd4})
            $display("FAIL bp_release: got r1=%b ce=%b a=%h want 1 1 4", m1_req_ready, rom_ce, rom_addr);
        else pass_cnt++;
        step();
        drive(0, 0, 1, 0, 0, 1);
        total_cnt++;
        if ({m0_rsp_valid, m1_rsp_valid, m1_rsp_data} !== {1'b0, 1'b1, rom_mem[4]})
            $display("FAIL bp_handover: got v=%b%b d1=%h want 01 %h", m0_rsp_valid, m1_rsp_valid, m1_rsp_data, rom_mem[4]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_rsp();
        drive(1, 64'hC, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        total_cnt++;
        if ({m0_rsp_valid, m0_rsp_data} !== {1'b1, rom_mem[3]})
            $display("FAIL mid_stalled: got v=%b d=%h want 1 %h", m0_rsp_valid, m0_rsp_data, rom_mem[3]);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({m0_rsp_valid, m0_rsp_data, rom_ce} !== 34'd0)
            $display("FAIL mid_reset: got v=%b d=%h ce=%b want 0 0 0", m0_rsp_valid, m0_rsp_data, rom_ce);
        else pass_cnt++;
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 64'h14, 1, 0, 0, 1);
        total_cnt++;
        if ({m0_req_ready, rom_ce, rom_addr} !== {1'b1, 1'b1, 64'd5})
            $display("FAIL mid_fresh_req: got r=%b ce=%b a=%h want 1 1 5", m0_req_ready, rom_ce, rom_addr);
        else pass_cnt++;
        step();
        drive(0, 0, 1, 0, 0, 1);
        total_cnt++;
        if ({m0_rsp_valid, m0_rsp_data} !== {1'b1, rom_mem[5]})
            $display("FAIL mid_fresh_rsp: got v=%b d=%h want 1 %h", m0_rsp_valid, m0_rsp_data, rom_mem[5]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_errors();
        drive(0, 0, 1, 1, 64'h6, 1);
        total_cnt++;
        if ({m1_req_ready, rom_ce} !== 2'b10)
            $display("FAIL err_misaligned_req: got r1=%b ce=%b want 1 0", m1_req_ready, rom_ce);
        else pass_cnt++;
        step();
        drive(1, 64'h100, 1, 0, 0, 1);
        total_cnt++;
        if ({m1_rsp_valid, m1_rsp_err, m1_rsp_data} !== {1'b1, 1'b1, 32'd0})
            $display("FAIL err_misaligned_rsp: got v=%b e=%b d=%h want 1 1 0", m1_rsp_valid, m1_rsp_err, m1_rsp_data);
        else pass_cnt++;
        total_cnt++;
        if ({m0_req_ready, rom_ce, rom_addr} !== {1'b1, 1'b0, 64'd0})
            $display("FAIL err_range_req: got r0=%b ce=%b a=%h want 1 0 0", m0_req_ready, rom_ce, rom_addr);
        else pass_cnt++;
        step();
        drive(0, 0, 1, 0, 0, 1);
        total_cnt++;
        if ({m0_rsp_valid, m0_rsp_err, m0_rsp_data} !== {1'b1, 1'b1, 32'd0})
            $display("FAIL err_range_rsp: got v=%b e=%b d=%h want 1 1 0", m0_rsp_valid, m0_rsp_err, m0_rsp_data);
        else pass_cnt++;
`ifdef ROM_ARB_STATS_EN
        total_cnt++;
        if (stat_err !== 16'd2)
            $display("FAIL err_stat: got %0d want 2", stat_err);
        else pass_cnt++;
`endif
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0);
            total_cnt++;
            if ({m0_req_ready, m1_req_ready, rom_ce, rom_addr} !== {e_rdy0, e_rdy1, e_ce, e_addr})
                $display("FAIL rand_req c=%0d: got %b%b ce=%b a=%h want %b%b ce=%b a=%h", c,
                         m0_req_ready, m1_req_ready, rom_ce, rom_addr, e_rdy0, e_rdy1, e_ce, e_addr);
            else pass_cnt++;
            total_cnt++;
            if ({m0_rsp_valid, m0_rsp_err, m0_rsp_data, m1_rsp_valid, m1_rsp_err, m1_rsp_data} !==
                {mv[0], me[0], md[0], mv[1], me[1], md[1]})
                $display("FAIL rand_rsp c=%0d: got %b%b %h %b%b %h want %b%b %h %b%b %h", c,
                         m0_rsp_valid, m0_rsp_err, m0_rsp_data, m1_rsp_valid, m1_rsp_err, m1_rsp_data,
                         mv[0], me[0], md[0], mv[1], me[1], md[1]);
            else pass_cnt++;
            step();
        end
`ifdef ROM_ARB_STATS_EN
        total_cnt++;
        if ({stat_grant0, stat_grant1, stat_stall, stat_err} !== {cnt_g[0], cnt_g[1], cnt_stall, cnt_err})
            $display("FAIL rand_stats: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     stat_grant0, stat_grant1, stat_stall, stat_err, cnt_g[0], cnt_g[1], cnt_stall, cnt_err);
        else pass_cnt++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
        rom_mem[0] = rom_mem[0] | 32'h1;
        rom_mem[2] = 32'h00100093;
        model_reset();
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_reset_mid_rsp();
        test_errors();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
